// File: rtl/td4_reg_write.sv
`default_nettype none
// ============================================================================
// Module   : td4_reg_write
// Purpose  : TD4 write-side register bank (A, B, OUT, PC) with PC increment
//            and registered carry flag, stepped by the divider clock-enable.
// Revision : 1.0 - initial release
// ============================================================================
module td4_reg_write #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             ce,
    input  logic             ld_en,
    input  logic [1:0]       ld_sel,
    input  logic [WIDTH-1:0] d,
    input  logic             carry_in,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] b_q,
    output logic [WIDTH-1:0] out_q,
    output logic [WIDTH-1:0] pc_q,
    output logic             c_flag
);

    localparam logic [1:0] c_SEL_A   = 2'b00;
    localparam logic [1:0] c_SEL_B   = 2'b01;
    localparam logic [1:0] c_SEL_OUT = 2'b10;
    localparam logic [1:0] c_SEL_PC  = 2'b11;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_pc;
    logic             r_c;

    logic             w_load_a;
    logic             w_load_b;
    logic             w_load_out;
    logic             w_load_pc;
    logic [WIDTH-1:0] w_pc_next;

    assign w_load_a   = ld_en && (ld_sel == c_SEL_A);
    assign w_load_b   = ld_en && (ld_sel == c_SEL_B);
    assign w_load_out = ld_en && (ld_sel == c_SEL_OUT);
    assign w_load_pc  = ld_en && (ld_sel == c_SEL_PC);

    // A jump replaces the increment for that step; otherwise PC wraps silently.
    assign w_pc_next  = w_load_pc ? d : r_pc + WIDTH'(1);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_out <= '0;
            r_pc  <= '0;
            r_c   <= 1'b0;
        end else if (ce) begin
            if (w_load_a)   r_a   <= d;
            if (w_load_b)   r_b   <= d;
            if (w_load_out) r_out <= d;
            r_pc <= w_pc_next;
            r_c  <= carry_in;
        end
    end

    assign a_q    = r_a;
    assign b_q    = r_b;
    assign out_q  = r_out;
    assign pc_q   = r_pc;
    assign c_flag = r_c;

endmodule
`default_nettype wire

// File: tb/tb_td4_reg_write.sv
`default_nettype none
// ============================================================================
// Module   : tb_td4_reg_write
// Purpose  : Self-checking bench for td4_reg_write (vector table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_td4_reg_write;

    localparam int WIDTH = 4;

    typedef struct {
        logic             ce;
        logic             ld_en;
        logic [1:0]       ld_sel;
        logic [WIDTH-1:0] d;
        logic             carry_in;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] o;
        logic [WIDTH-1:0] pc;
        logic             c;
    } vec_t;

    logic             clk;
    logic             n_reset;
    logic             ce;
    logic             ld_en;
    logic [1:0]       ld_sel;
    logic [WIDTH-1:0] d;
    logic             carry_in;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] pc_q;
    logic             c_flag;

    vec_t               vecs[$];
    logic [4*WIDTH:0]   sb[$];
    int                 checks = 0;
    int                 errors = 0;

    td4_reg_write #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .ce       (ce),
        .ld_en    (ld_en),
        .ld_sel   (ld_sel),
        .d        (d),
        .carry_in (carry_in),
        .a_q      (a_q),
        .b_q      (b_q),
        .out_q    (out_q),
        .pc_q     (pc_q),
        .c_flag   (c_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic c_e, input logic en, input logic [1:0] sel,
                       input logic [WIDTH-1:0] dd, input logic cin,
                       input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb,
                       input logic [WIDTH-1:0] eo, input logic [WIDTH-1:0] epc,
                       input logic ec);
        vec_t v;
        v.ce = c_e; v.ld_en = en; v.ld_sel = sel; v.d = dd; v.carry_in = cin;
        v.a = ea; v.b = eb; v.o = eo; v.pc = epc; v.c = ec;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [4*WIDTH:0] exp_v);
        logic [4*WIDTH:0] act;
        act = {a_q, b_q, out_q, pc_q, c_flag};
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got a=%h b=%h out=%h pc=%h c=%b, expected a=%h b=%h out=%h pc=%h c=%b",
                     name, act[16:13], act[12:9], act[8:5], act[4:1], act[0],
                     exp_v[16:13], exp_v[12:9], exp_v[8:5], exp_v[4:1], exp_v[0]);
        end
    endtask

    initial begin
        n_reset = 1'b0; ce = 1'b0; ld_en = 1'b0; ld_sel = 2'b00; d = '0; carry_in = 1'b0;

        //   ce en sel    d     cin   a     b     out   pc    c
        add(1, 0, 2'b00, 4'h0, 0,    4'h0, 4'h0, 4'h0, 4'h1, 0);  // plain steps
        add(1, 0, 2'b00, 4'h0, 0,    4'h0, 4'h0, 4'h0, 4'h2, 0);
        add(1, 0, 2'b00, 4'h0, 0,    4'h0, 4'h0, 4'h0, 4'h3, 0);
        add(1, 1, 2'b00, 4'h5, 0,    4'h5, 4'h0, 4'h0, 4'h4, 0);  // write A
        add(1, 1, 2'b01, 4'hA, 0,    4'h5, 4'hA, 4'h0, 4'h5, 0);  // write B
        add(1, 1, 2'b10, 4'h3, 0,    4'h5, 4'hA, 4'h3, 4'h6, 0);  // write OUT
        add(1, 1, 2'b11, 4'h2, 0,    4'h5, 4'hA, 4'h3, 4'h2, 0);  // jump, no +1
        add(1, 0, 2'b11, 4'h9, 0,    4'h5, 4'hA, 4'h3, 4'h3, 0);
        add(1, 1, 2'b11, 4'hF, 0,    4'h5, 4'hA, 4'h3, 4'hF, 0);
        add(1, 0, 2'b00, 4'h0, 1,    4'h5, 4'hA, 4'h3, 4'h0, 1);  // wrap + carry
        add(1, 0, 2'b00, 4'h0, 0,    4'h5, 4'hA, 4'h3, 4'h1, 0);
        for (int i = 0; i < 5; i++)                                // hold
            add(0, 1, 2'b00, 4'hF, 1, 4'h5, 4'hA, 4'h3, 4'h1, 0);
        add(1, 1, 2'b01, 4'h7, 1,    4'h5, 4'h7, 4'h3, 4'h2, 1);
        add(1, 1, 2'b11, 4'h9, 1,    4'h5, 4'h7, 4'h3, 4'h9, 1);

        #1;
        check("reset_async", '0);
        @(posedge clk); #1;
        check("reset_held_clk", '0);
        @(negedge clk);
        n_reset = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            ce = vecs[i].ce; ld_en = vecs[i].ld_en; ld_sel = vecs[i].ld_sel;
            d = vecs[i].d; carry_in = vecs[i].carry_in;
            sb.push_back({vecs[i].a, vecs[i].b, vecs[i].o, vecs[i].pc, vecs[i].c});
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), sb.pop_front());
        end

        // Async reset between edges, with ce high across an edge while held.
        @(negedge clk);
        ce = 1'b1; ld_en = 1'b1; ld_sel = 2'b00; d = 4'h6; carry_in = 1'b1;
        #2 n_reset = 1'b0;
        #1 check("reset_midcycle", '0);
        @(posedge clk); #1;
        check("reset_beats_ce", '0);
        @(negedge clk);
        n_reset = 1'b1; ld_en = 1'b0; carry_in = 1'b0;
        sb.push_back({4'h0, 4'h0, 4'h0, 4'h1, 1'b0});
        @(posedge clk); #1;
        check("first_step_after_reset", sb.pop_front());
        @(negedge clk);
        ce = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/td4_reg_write.md
# td4_reg_write

Write-side register bank of the TD4 datapath, the counterpart of the 4:1 source-select multiplexer that feeds the ALU. It takes the ALU result and, under a 2-bit destination select, loads exactly one of the four architectural registers: A, B, OUT or PC. It also owns PC auto-increment and the carry flag. Every state change is gated by a clock-enable from the slow-clock divider.

## Interface
- WIDTH, 4, data width of every register and of the ALU result.

- clk  input  1  system clock; all state updates on the rising edge.
- n_reset  input  1  asynchronous, active-low reset.
- ce  input  1  step enable; state updates only when 1 at the rising edge.
- ld_en  input  1  write strobe; when 1, the register selected by ld_sel loads d.
- ld_sel  input  2  destination select: 00 = A, 01 = B, 10 = OUT, 11 = PC.
- d  input  WIDTH  ALU sum to be written.
- carry_in  input  1  ALU carry-out for the current instruction.
- a_q  output  WIDTH  register A.
- b_q  output  WIDTH  register B.
- out_q  output  WIDTH  OUT port register, drives the LEDs.
- pc_q  output  WIDTH  program counter.
- c_flag  output  1  registered carry; consumed by the JNC decode.

## Operation
- Reset (n_reset = 0, asynchronous, independent of clk and ce):
  - a_q = b_q = out_q = pc_q = 0.
  - c_flag = 0.
  - Release takes effect at the next qualifying edge.
- Step (rising clk with ce = 1) applies all of the following in the same edge:
  - Destination decode: ld_en = 1 loads d into exactly the one register chosen by ld_sel. Registers not selected hold.
  - ld_en = 0: no data register loads.
  - PC:
    - if ld_en = 1 and ld_sel = 11, pc_q <= d (jump); no increment that step.
    - otherwise pc_q <= pc_q + 1, modulo 2^WIDTH (15 -> 0 for WIDTH = 4, no flag).
  - Carry: c_flag <= carry_in on every step, whatever ld_en and ld_sel are.
- ce = 0: every register and c_flag hold, including PC. Inputs are ignored.
- No combinational path from any input to any output. All outputs come straight from flops.
- Write and read of the same register in one step: the mux side sees the old value for the whole cycle. The new value appears after the edge.

## Timing
- Write latency: 1 qualifying edge from ld_en/d to the updated register output.
- PC advances exactly once per ce pulse. There is no extra cycle for jumps.
- ce is a single-cycle pulse from the divider. Back-to-back ce = 1 cycles must give back-to-back steps: n high cycles give n increments.
- Reset asserted mid-step, even coincident with a rising edge where ce = 1: reset wins, and every output is 0 while n_reset = 0.
- Inputs must be stable at the rising edge only when ce = 1. Outside that they are don't-care.

## Test plan
- Reset, then 3 edges with ce = 1 and ld_en = 0 -> pc_q = 1, 2, 3 after successive steps; a_q, b_q and out_q stay 0.
- Write sequence (ce = 1, ld_en = 1):
  - ld_sel = 00, d = 0x5 -> a_q = 5.
  - next step, ld_sel = 01, d = 0xA -> b_q = A, a_q still 5.
  - next step, ld_sel = 10, d = 0x3 -> out_q = 3.
  - PC increments on all three steps.
- Jump: pc_q = 6, ld_sel = 11, d = 0x2 -> pc_q = 2 (not 7). The following plain step -> pc_q = 3.
- Wrap and carry:
  - pc_q = 0xF, ld_en = 0, carry_in = 1 -> pc_q = 0, c_flag = 1.
  - next step with carry_in = 0 -> c_flag = 0.
- Hold: ce = 0 for 5 edges with ld_en = 1, ld_sel = 00, d = 0xF, carry_in = 1 -> no output changes.
- Async reset: with a_q = 5, pc_q = 9, c_flag = 1, assert n_reset between edges -> all outputs 0 immediately, without a clock edge. Deassert; the first ce step -> pc_q = 1.
